// File: rtl/data_mem_sync.sv
// data_mem_sync: registered, handshaked byte-lane data memory with a self-clearing reset sweep
// Ports: CLK/Reset (sync, active-high); req/we/size/sign_ext/addr/wdata request side;
// ready (accepting), rvalid (load result pulse), rdata (held load result), err (reject pulse).
module data_mem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int DW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t              state_q, state_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [LB-1:0]       lane;
  logic [DW-1:0]       idx;
  logic                accept, oor, bad, st_en, msb;
  logic [NB-1:0]       be;
  logic [DATA_W-1:0]   word, shifted, wdata_sh, merged, fmask, ld_val;
  assign lane     = addr[LB-1:0];
  assign idx      = addr[LB+DW-1:LB];
  assign accept   = req & ready;
  // any address bit above the word index means the word lies beyond DEPTH
  assign oor      = (addr >> (LB + DW)) != '0;
  assign bad      = (size == 2'b11) | (size == 2'b01 & addr[0]) | (size == 2'b10 & lane != '0) | oor;
  assign st_en    = accept & we & ~bad;
  assign word     = mem[idx];
  assign shifted  = word >> {lane, 3'b000};
  assign wdata_sh = wdata << {lane, 3'b000};
  assign be       = ((size == 2'b00) ? NB'(1) : (size == 2'b01) ? NB'(3) : {NB{1'b1}}) << lane;
  // the field mask doubles as the extension mask: its complement is the fill region
  assign fmask    = (size == 2'b00) ? DATA_W'(8'hFF) : (size == 2'b01) ? DATA_W'(16'hFFFF) : '1;
  assign msb      = (size == 2'b00) ? shifted[7] : shifted[15];
  assign ld_val   = (shifted & fmask) | ((sign_ext & msb) ? ~fmask : '0);
  always_comb begin
    merged = word;
    for (int b = 0; b < NB; b++) merged[8*b +: 8] = be[b] ? wdata_sh[8*b +: 8] : word[8*b +: 8];
  end
  always_ff @(posedge CLK)
    if (Reset) state_q <= CLEAR;
    else state_q <= state_d;
  always_comb state_d = (state_q == CLEAR && cnt_q == DW'(DEPTH - 1)) ? RUN : state_q;
  always_comb ready = state_q == RUN;
  always_comb begin
    cnt_d    = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
    rvalid_d = accept & ~we & ~bad;
    err_d    = accept & bad;
    rdata_d  = rvalid_d ? ld_val : rdata_q;
  end
  always_ff @(posedge CLK)
    if (Reset) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  // contents survive Reset; only the CLEAR sweep zeroes them
  always_ff @(posedge CLK)
    if (!Reset && state_q == CLEAR) mem[cnt_q] <= '0;
    else if (!Reset && st_en) mem[idx] <= merged;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: vector table, reset corner sequences and random traffic against a byte-array model
module tb_data_mem_sync;
  localparam int DEPTH = 32;
  localparam int NB = 4;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic        er;
    logic [31:0] rd;
  } vec_t;
  logic CLK = 1'b0, Reset = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic ready, rvalid, err;
  int vecs = 0, miscmp = 0;
  logic [7:0] mem_m [DEPTH*NB];
  logic exp_rv, exp_err;
  logic [31:0] exp_rd;
  vec_t tbl[$];
  data_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    exp_rd = '0;
    exp_rv = 1'b0;
    exp_err = 1'b0;
  endtask
  task automatic model(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [31:0] v;
    exp_rv = 1'b0;
    exp_err = 1'b0;
    if (!r) return;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (sz == 2'b11 || (a % n) != 0 || a >= DEPTH*NB) begin
      exp_err = 1'b1;
      return;
    end
    if (w) begin
      for (int i = 0; i < n; i++) mem_m[a+i] = d[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a+i];
    if (sx && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    exp_rd = v;
    exp_rv = 1'b1;
  endtask
  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    model(r, w, sz, sx, a, d);
    step();
    req = 1'b0;
  endtask
  task automatic wait_clear(input string nm);
    int n = 0;
    while (!ready && n < 100) begin
      n++;
      step();
    end
    chk(nm, n, 32);
    model_reset();
  endtask
  initial begin
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00000000});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        1'b1, 1'b0, 32'h00000000});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h11, 32'h80,       1'b0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEAD80EF});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        1'b1, 1'b0, 32'h00000080});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        1'b1, 1'b0, 32'hFFFFDEAD});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF,     1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h90, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFDEAD});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00000000});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEAD80EF});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234,     1'b0, 1'b0, 32'hDEAD80EF});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h123480EF});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        1'b1, 1'b0, 32'hFFFF80EF});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h000080EF});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b1, 1'b0, 32'h00000012});
    step();
    step();
    chk("reset_ready", ready, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_err", err, 0);
    chk("reset_rdata", rdata, 0);
    Reset = 1'b0;
    wait_clear("clear_len");
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("idle_rvalid", rvalid, 0);
    chk("idle_rdata_hold", rdata, 32'h000000_12);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("pre_rst_rvalid", rvalid, 1);
    Reset = 1'b1;
    step();
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_err", err, 0);
    Reset = 1'b0;
    wait_clear("clear_after_load");
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("cleared_rvalid", rvalid, 1);
    chk("cleared_word10", rdata, 32'h0);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 32'h12345678);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (10) step();
    chk("cnt10_ready", ready, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    wait_clear("clear_restart10");
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);
    chk("restart_word31", rdata, 32'h0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    chk("restart_word0", rdata, 32'h0);
    chk("restart_rvalid", rvalid, 1);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 200)) : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a = (sz == 2'b01) ? {a[31:1], 1'b0} : (sz == 2'b10) ? {a[31:2], 2'b00} : a;
      drive($urandom_range(0, 4) != 0, 1'($urandom), sz, 1'($urandom), a, $urandom);
      chk($sformatf("rnd%0d_rvalid", i), rvalid, exp_rv);
      chk($sformatf("rnd%0d_err", i), err, exp_err);
      chk($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
      chk($sformatf("rnd%0d_ready", i), ready, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
